// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetcher feeding a valid/ready FIFO; stops at HALT_OP.
// Optional abort input when IFU_ABORT_EN is defined.
module instr_fetch_unit #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH = 4,
   parameter logic [7:0] HALT_OP = 8'hFF
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
`ifdef IFU_ABORT_EN
   input  logic                abort,
`endif
   input  logic                start,
   input  logic [ADDR_W-1:0]   start_addr,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   instruction_mem_address,
   output logic                instruction_mem_chipselect,
   output logic                instruction_mem_clken,
   output logic                instruction_mem_write,
   input  logic [DATA_W-1:0]   instruction_mem_readdata,
   output logic [DATA_W-1:0]   instruction_mem_writedata,
   output logic [DATA_W/8-1:0] instruction_mem_byteenable,
   output logic [DATA_W-1:0]   instr_data,
   output logic [ADDR_W-1:0]   instr_pc,
   output logic                instr_valid,
   input  logic                instr_ready
);
   localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2;
   localparam int PW = $clog2(FIFO_DEPTH), CW = PW + 2;
   logic [1:0] state;
   logic [ADDR_W-1:0] next_addr;
   logic [READ_LATENCY-1:0] tag_v;
   logic [ADDR_W-1:0] tag_a [READ_LATENCY];
   logic [DATA_W-1:0] fifo_d [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_a [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, inflight;
   logic abort_i, issue, cap, cap_halt, pop, done_q;
`ifdef IFU_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif
   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(tag_v[i]);
   end
   // responses are only captured while fetching, so words behind the HALT are dropped
   assign cap = tag_v[READ_LATENCY-1] && state == FETCH;
   assign cap_halt = cap && instruction_mem_readdata[DATA_W-1 -: 8] == HALT_OP;
   // credit rule: every outstanding read has a reserved FIFO slot
   assign issue = state == FETCH && !cap_halt && !abort_i && (inflight + count) < CW'(FIFO_DEPTH);
   assign instr_valid = count != '0;
   assign pop = instr_valid && instr_ready;
   assign busy = state != IDLE;
   assign done = done_q;
   assign instruction_mem_address = next_addr;
   assign instruction_mem_chipselect = issue;
   assign instruction_mem_clken = busy;
   assign instruction_mem_write = 1'b0;
   assign instruction_mem_writedata = '0;
   assign instruction_mem_byteenable = '1;
   assign instr_data = instr_valid ? fifo_d[rd_ptr] : '0;
   assign instr_pc = instr_valid ? fifo_a[rd_ptr] : '0;
   always_ff @(posedge clk_clk) begin
      if (reset_reset || (abort_i && state != IDLE)) begin
         state <= IDLE;
         next_addr <= '0;
         tag_v <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         done_q <= 1'b0;
      end else begin
         assert (!(cap && count == CW'(FIFO_DEPTH)));
         done_q <= 1'b0;
         tag_v[0] <= issue;
         tag_a[0] <= next_addr;
         for (int i = READ_LATENCY - 1; i > 0; i--) begin
            tag_v[i] <= tag_v[i-1];
            tag_a[i] <= tag_a[i-1];
         end
         if (issue) next_addr <= next_addr + ADDR_W'(1);
         if (cap) begin
            fifo_d[wr_ptr] <= instruction_mem_readdata;
            fifo_a[wr_ptr] <= tag_a[READ_LATENCY-1];
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(cap) - CW'(pop);
         if (state == IDLE && start && !abort_i) begin
            state <= FETCH;
            next_addr <= start_addr;
         end
         if (cap_halt) state <= DRAIN;
         // nothing is pushed after the HALT, so the last word popped in DRAIN is the HALT
         if (state == DRAIN && pop && count == CW'(1)) begin
            state <= IDLE;
            done_q <= 1'b1;
         end
      end
   end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- FPGA-side reader of the on-chip instruction memory. The HPS writes a program into that memory over its port; this block drives the memory's FPGA port.
- On a start pulse it fetches 32-bit instruction words sequentially from a base address, buffers them in a small FIFO, and presents them to the downstream decoder over a valid/ready stream.
- It stops at a HALT word and signals completion.

Parameters:
- ADDR_W, 10, instruction memory word-address width
- DATA_W, 32, instruction word width
- READ_LATENCY, 1, memory read latency in cycles; legal values 1 or 2
- FIFO_DEPTH, 4, output buffer depth in words; power of 2, minimum 2
- HALT_OP, 8'hFF, opcode in bits [31:24] that terminates a program

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a fetch at start_addr
- start_addr  in  ADDR_W  first word address
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse when HALT is consumed downstream
- instruction_mem_address  out  ADDR_W  read address
- instruction_mem_chipselect  out  1  read strobe, one cycle per word
- instruction_mem_clken  out  1  memory clock enable
- instruction_mem_write  out  1  constant 0
- instruction_mem_readdata  in  DATA_W  read data, valid READ_LATENCY cycles after strobe
- instruction_mem_writedata  out  DATA_W  constant 0
- instruction_mem_byteenable  out  DATA_W/8  constant all ones
- instr_data  out  DATA_W  FIFO head word
- instr_pc  out  ADDR_W  address of instr_data
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  consumer accepts head when instr_valid & instr_ready

Behaviour:
- Reset values: all outputs 0 (busy, done, instr_valid, chipselect, address, instr_data, instr_pc); FIFO empty; in-flight count 0; state IDLE. Reset mid-fetch abandons everything, with no done pulse.
- State IDLE:
  - start → FETCH, next_addr = start_addr, busy = 1 on the following cycle.
  - start while busy is ignored.
- State FETCH:
  - Issue a read (chipselect = 1, address = next_addr) when inflight + fifo_count < FIFO_DEPTH.
  - next_addr increments modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0.
  - At most one issue per cycle.
  - clken = busy.
- Response capture: a shift register of depth READ_LATENCY tags each issue (valid bit + address). When the tag emerges, readdata and the tagged address are pushed into the FIFO. The credit rule guarantees the FIFO never overflows.
- HALT detection:
  - A captured word with [31:24] == HALT_OP is pushed, then the state moves to DRAIN.
  - Issue stops the same cycle.
  - Responses still in flight after the HALT word are discarded, not pushed.
- State DRAIN:
  - The FIFO continues to drain.
  - When the HALT word is accepted (instr_valid & instr_ready on it): done = 1 for one cycle, busy = 0 in that same cycle, → IDLE.
- FIFO rules:
  - Simultaneous push and pop is allowed, and count is unchanged.
  - Push when full is impossible by construction (assertion).
  - instr_valid = count != 0.
  - instr_data and instr_pc hold stable while instr_valid & !instr_ready.
- Throughput: one word per cycle sustained when instr_ready is held at 1.
- Latency: start at cycle 0 → first chipselect at cycle 1 → instr_valid at cycle 1 + READ_LATENCY + 1.

Optional Feature:
- Macro IFU_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high in any state except IDLE: on the next edge, FIFO is flushed, in-flight tags are invalidated, chipselect = 0, busy = 0, and state → IDLE. No done pulse.
  - abort together with start in IDLE: abort wins and start is ignored.
- Undefined:
  - Port is absent.
  - The only exits from a fetch are HALT consumption and reset.

Test Plan:
- Memory [0x010..0x013] = 0x11, 0x22, 0x33, 0xFF000000; start, start_addr = 0x010; instr_ready = 1 → instr_pc 0x010..0x013 with matching data, one word per cycle; done pulses on acceptance of 0xFF000000; no reads issued beyond 0x014 + READ_LATENCY.
- Same program with instr_ready = 0 for 20 cycles → chipselect count stops at FIFO_DEPTH (4); instr_data holds 0x11; after release, all 4 words are delivered in order.
- start_addr = 0x3FE; memory [0x3FE] = 1, [0x3FF] = 2, [0x000] = 0xFF000000 → instr_pc sequence 0x3FE, 0x3FF, 0x000; done asserted.
- READ_LATENCY = 2; HALT at 0x005, start_addr = 0x004; nonzero data after 0x005 → the words at 0x006/0x007 are never presented; done after HALT.
- reset_reset asserted for 1 cycle while 2 words are buffered → next cycle instr_valid = 0, busy = 0, no done; a new start at 0x020 fetches correctly.
- IFU_ABORT_EN: abort in the cycle after the third chipselect → instr_valid = 0 and busy = 0 on the next cycle; no done pulse; no further chipselect.
